// File: rtl/llc_evict_wb_buffer.sv
// Writeback buffer for LLC victims: queues Modified lines for line-aligned
// writeback, drops and counts clean/invalid ones, and answers snoops on pending lines.
module llc_evict_wb_buffer #(
  parameter int ADDR_W   = 32,
  parameter int SET_W    = 14,
  parameter int OFFSET_W = 6,
  parameter int TAG_W    = ADDR_W - SET_W - OFFSET_W,
  parameter int N_WAY    = 16,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     evict_valid,
  output logic                     evict_ready,
  input  logic [SET_W-1:0]         evict_set,
  input  logic [$clog2(N_WAY)-1:0] evict_way,
  input  logic [TAG_W-1:0]         evict_tag,
  input  logic [1:0]               evict_mesi,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [$clog2(N_WAY)-1:0] wb_way,
  input  logic                     snoop_valid,
  input  logic [ADDR_W-1:0]        snoop_addr,
  output logic                     snoop_hit,
  output logic [CNT_W-1:0]         wb_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int WAY_W  = $clog2(N_WAY);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int LINE_W = TAG_W + SET_W;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_EMPTY = {OCC_W{1'b0}};
  localparam logic [1:0]       MESI_M    = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [LINE_W-1:0] line_r [DEPTH];
  logic [WAY_W-1:0]  way_r  [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [OCC_W-1:0]  occ_r;

  logic              accept_s;
  logic              push_s;
  logic              drop_s;
  logic              pop_s;
  logic [LINE_W-1:0] evict_line_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [OCC_W-1:0]  occ_nxt_s;
  logic [LINE_W-1:0] head_line_nxt_s;
  logic [WAY_W-1:0]  head_way_nxt_s;
  logic              snoop_match_s;

  // Handshakes, next pointers/occupancy, and the head entry after this edge
  always_comb begin
    accept_s     = evict_valid && evict_ready;
    push_s       = accept_s && (evict_mesi == MESI_M);
    drop_s       = accept_s && (evict_mesi != MESI_M);
    pop_s        = wb_valid && wb_ready;
    evict_line_s = {evict_tag, evict_set};
    wr_ptr_nxt_s = push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
    rd_ptr_nxt_s = pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
      2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
      default: occ_nxt_s = occ_r;
    endcase
    // The slot being written becomes the head only when the FIFO drains to it
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_line_nxt_s = evict_line_s;
      head_way_nxt_s  = evict_way;
    end else begin
      head_line_nxt_s = line_r[rd_ptr_nxt_s];
      head_way_nxt_s  = way_r[rd_ptr_nxt_s];
    end
  end

  // Snoop match against entries valid before the edge (push excluded, pop included)
  always_comb begin
    snoop_match_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      snoop_match_s = snoop_match_s |
                      (valid_r[i] && (line_r[i] == snoop_addr[ADDR_W-1:OFFSET_W]));
    end
  end

  // Entry payload; qualified by valid_r, so it needs no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      line_r[wr_ptr_r] <= evict_line_s;
      way_r[wr_ptr_r]  <= evict_way;
    end
  end

  // Entry valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {DEPTH{1'b0}};
    end else begin
      if (push_s) valid_r[wr_ptr_r] <= 1'b1;
      if (pop_s)  valid_r[rd_ptr_r] <= 1'b0;
    end
  end

  // Pointers, occupancy and registered bus-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      occ_r       <= OCC_EMPTY;
      evict_ready <= 1'b1;
      wb_valid    <= 1'b0;
      wb_addr     <= {ADDR_W{1'b0}};
      wb_way      <= {WAY_W{1'b0}};
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      occ_r       <= occ_nxt_s;
      evict_ready <= (occ_nxt_s != OCC_FULL);
      wb_valid    <= (occ_nxt_s != OCC_EMPTY);
      if (occ_nxt_s != OCC_EMPTY) begin
        wb_addr <= {head_line_nxt_s, {OFFSET_W{1'b0}}};
        wb_way  <= head_way_nxt_s;
      end else begin
        wb_addr <= {ADDR_W{1'b0}};
        wb_way  <= {WAY_W{1'b0}};
      end
    end
  end

  // Snoop response and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snoop_hit  <= 1'b0;
      wb_count   <= {CNT_W{1'b0}};
      drop_count <= {CNT_W{1'b0}};
    end else begin
      snoop_hit <= snoop_valid && snoop_match_s;
      if (pop_s && (wb_count != CNT_MAX)) wb_count <= wb_count + CNT_W'(1);
      if (drop_s && (drop_count != CNT_MAX)) drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_llc_evict_wb_buffer.sv
// Randomised bench for llc_evict_wb_buffer against a queue-based reference model.
module tb_llc_evict_wb_buffer;

  localparam int ADDR_W = 32;
  localparam int SET_W = 14;
  localparam int OFFSET_W = 6;
  localparam int TAG_W = 12;
  localparam int N_WAY = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [25:0] line;
    logic [3:0]  way;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic evict_valid, evict_ready;
  logic [13:0] evict_set;
  logic [3:0] evict_way;
  logic [11:0] evict_tag;
  logic [1:0] evict_mesi;
  logic wb_valid, wb_ready;
  logic [31:0] wb_addr;
  logic [3:0] wb_way;
  logic snoop_valid;
  logic [31:0] snoop_addr;
  logic snoop_hit;
  logic [CNT_W-1:0] wb_count, drop_count;

  ent_t q[$];
  int m_wbc, m_drop;
  logic m_hit;
  int checks, errors;

  llc_evict_wb_buffer #(
    .ADDR_W(ADDR_W), .SET_W(SET_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W),
    .N_WAY(N_WAY), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_set(evict_set), .evict_way(evict_way), .evict_tag(evict_tag),
    .evict_mesi(evict_mesi),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_way(wb_way),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
    .wb_count(wb_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model's current state
  task automatic compare_all();
    chk("evict_ready", 32'(evict_ready), 32'(q.size() != DEPTH));
    chk("wb_valid", 32'(wb_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("wb_addr", wb_addr, {q[0].line, 6'b000000});
      chk("wb_way", 32'(wb_way), 32'(q[0].way));
    end
    chk("snoop_hit", 32'(snoop_hit), 32'(m_hit));
    chk("wb_count", 32'(wb_count), 32'(m_wbc));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic model_reset();
    q.delete();
    m_wbc = 0;
    m_drop = 0;
    m_hit = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge
  task automatic step(input logic ev, input logic [13:0] set, input logic [3:0] way,
                      input logic [11:0] tag, input logic [1:0] mesi, input logic wbr,
                      input logic sv, input logic [31:0] sa);
    logic rdy, vld, hit;
    ent_t e;
    evict_valid = ev; evict_set = set; evict_way = way; evict_tag = tag;
    evict_mesi = mesi; wb_ready = wbr; snoop_valid = sv; snoop_addr = sa;
    rdy = (q.size() != DEPTH);
    vld = (q.size() != 0);
    hit = 1'b0;
    foreach (q[i]) if (q[i].line == sa[31:6]) hit = 1'b1;
    m_hit = sv && hit;
    if (vld && wbr) begin
      void'(q.pop_front());
      if (m_wbc < CNT_MAX) m_wbc++;
    end
    if (ev && rdy) begin
      if (mesi == 2'b11) begin
        e.line = {tag, set};
        e.way = way;
        q.push_back(e);
      end else if (m_drop < CNT_MAX) begin
        m_drop++;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input logic wbr);
    step(1'b0, 14'h0, 4'h0, 12'h0, 2'b00, wbr, 1'b0, 32'h0);
  endtask

  initial begin
    logic [11:0] t;
    logic [13:0] s;
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 1'b0;
    evict_valid = 1'b0; evict_set = 14'h0; evict_way = 4'h0; evict_tag = 12'h0;
    evict_mesi = 2'b00; wb_ready = 1'b0; snoop_valid = 1'b0; snoop_addr = 32'h0;
    #12;
    compare_all();
    chk("rst_wb_addr", wb_addr, 32'h0);
    #9 rst_n = 1'b1;

    // Idle with a snoop: nothing pending, no hit
    step(1'b0, 14'h0, 4'h0, 12'h0, 2'b00, 1'b1, 1'b1, 32'h0AB48D00);
    chk("idle_snoop", 32'(snoop_hit), 32'h0);

    // Clean/invalid victims are dropped
    for (int m = 0; m < 3; m++)
      step(1'b1, 14'h1234, 4'd5, 12'h0AB, 2'(m), 1'b1, 1'b0, 32'h0);
    chk("drop3", 32'(drop_count), 32'd3);
    chk("drop_no_wb", 32'(wb_valid), 32'h0);

    // Single M victim, wb_ready held high
    step(1'b1, 14'h1234, 4'd5, 12'h0AB, 2'b11, 1'b1, 1'b0, 32'h0);
    chk("single_valid", 32'(wb_valid), 32'h1);
    chk("single_addr", wb_addr, 32'h0AB48D00);
    chk("single_way", 32'(wb_way), 32'd5);
    idle(1'b1);
    chk("single_count", 32'(wb_count), 32'd1);
    chk("single_empty", 32'(wb_valid), 32'h0);

    // Fill to full, stall a fifth, then drain in order
    for (int i = 0; i < 4; i++)
      step(1'b1, 14'(i), 4'(i), 12'(12'h100 + i), 2'b11, 1'b0, 1'b0, 32'h0);
    chk("full_ready", 32'(evict_ready), 32'h0);
    step(1'b1, 14'h3FFF, 4'hF, 12'h200, 2'b11, 1'b0, 1'b0, 32'h0);
    chk("stall_head", wb_addr, 32'h10000000);
    step(1'b1, 14'h3FFF, 4'hF, 12'h200, 2'b11, 1'b1, 1'b0, 32'h0);
    chk("ready_after_pop", 32'(evict_ready), 32'h1);
    step(1'b1, 14'h3FFF, 4'hF, 12'h200, 2'b11, 1'b1, 1'b0, 32'h0);
    repeat (5) idle(1'b1);

    // Snoop timing around push and pop
    step(1'b1, 14'h1234, 4'd5, 12'h0AB, 2'b11, 1'b0, 1'b1, 32'h0AB48D3F);
    chk("snoop_push", 32'(snoop_hit), 32'h0);
    step(1'b0, 14'h0, 4'h0, 12'h0, 2'b00, 1'b0, 1'b1, 32'h0AB48D3F);
    chk("snoop_pend", 32'(snoop_hit), 32'h1);
    step(1'b0, 14'h0, 4'h0, 12'h0, 2'b00, 1'b0, 1'b1, 32'h0AB48D40);
    chk("snoop_next_line", 32'(snoop_hit), 32'h0);
    step(1'b0, 14'h0, 4'h0, 12'h0, 2'b00, 1'b1, 1'b1, 32'h0AB48D3F);
    chk("snoop_pop", 32'(snoop_hit), 32'h1);
    step(1'b0, 14'h0, 4'h0, 12'h0, 2'b00, 1'b1, 1'b0, 32'h0AB48D3F);
    chk("snoop_off", 32'(snoop_hit), 32'h0);

    // Random traffic over a tiny line space for duplicates, hits and saturation
    for (int n = 0; n < 600; n++) begin
      t = 12'($urandom_range(0, 3));
      s = 14'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), s, 4'($urandom_range(0, 15)), t,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)),
           {12'($urandom_range(0, 3)), 14'($urandom_range(0, 3)), 6'($urandom_range(0, 63))});
    end
    repeat (6) idle(1'b1);

    // Asynchronous reset with entries pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 14'(i + 7), 4'(i), 12'h0CD, 2'b11, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_valid", 32'(wb_valid), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_valid", 32'(wb_valid), 32'h0);
    chk("async_rst_addr", wb_addr, 32'h0);
    #7 rst_n = 1'b1;
    repeat (4) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/llc_evict_wb_buffer.md
Name: llc_evict_wb_buffer

Overview:
- Downstream of LLC victim selection: when a miss replaces a way, the chosen victim line (set, way, tag, MESI) is offered to this block.
- Modified (M) victims are queued in a small FIFO and issued as line-aligned writebacks on the bus-side handshake. Non-M victims are dropped and counted.
- Answers line-address snoops against pending writebacks, so the coherence logic can find dirty data that has left the array but not yet reached memory.

Parameters:
ADDR_W, 32, byte address width
SET_W, 14, set index width (16K sets)
OFFSET_W, 6, line offset width (64-byte line)
TAG_W, ADDR_W-SET_W-OFFSET_W (12), tag width
N_WAY, 16, ways per set
DEPTH, 4, writeback FIFO entries (power of two, at least 2)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
evict_valid  in  1  victim offered
evict_ready  out  1  victim accepted when high together with evict_valid
evict_set  in  SET_W  victim set index
evict_way  in  $clog2(N_WAY)  victim way
evict_tag  in  TAG_W  victim tag
evict_mesi  in  2  victim state; I=00 S=01 E=10 M=11
wb_valid  out  1  writeback pending at FIFO head
wb_ready  in  1  bus accepts writeback
wb_addr  out  ADDR_W  {tag,set,OFFSET_W'0} of head entry
wb_way  out  $clog2(N_WAY)  way of head entry (for data read-out)
snoop_valid  in  1  snoop lookup request
snoop_addr  in  ADDR_W  snoop byte address (offset bits ignored)
snoop_hit  out  1  registered: snoop matched a pending entry
wb_count  out  CNT_W  writebacks issued, saturating
drop_count  out  CNT_W  clean/invalid victims dropped, saturating

Behaviour:
- Reset (async, rst_n=0):
  - All entries invalid; read/write pointers and occupancy count = 0.
  - wb_valid=0, wb_addr=0, wb_way=0, snoop_hit=0, wb_count=0, drop_count=0, evict_ready=1.
  - Reset mid-transfer discards all pending entries; nothing is issued after release.
- Storage: circular FIFO with DEPTH entries.
  - Each entry holds valid, tag, set, way.
  - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - A separate occupancy count (0..DEPTH) distinguishes full from empty.
- Accept:
  - evict_ready = (count != DEPTH); registered-state function only, with no combinational path from wb_ready.
  - Handshake is evict_valid && evict_ready.
- Victims with evict_mesi == M: written to the entry at the write pointer; the pointer advances.
- Victims with evict_mesi in {I, S, E}: accepted (a handshake still occurs), not stored; drop_count increments.
  - A non-M victim is accepted even when the FIFO is full? No: evict_ready is uniformly low when full, so non-M victims also stall.
- Issue:
  - wb_valid = (count != 0). wb_addr and wb_way are driven from the head entry.
  - An entry pushed at edge N is visible on wb_valid/wb_addr after edge N (latency 1 cycle, no bypass).
  - Pop on wb_valid && wb_ready: the head entry is invalidated, the read pointer advances, and wb_count increments.
  - The head must hold stable while wb_valid=1 and wb_ready=0.
- Simultaneous push and pop (count in 1..DEPTH-1): both occur; count is unchanged; FIFO order is preserved.
- Push and pop when full: not possible, because evict_ready=0. Pop proceeds and evict_ready rises the next cycle.
- Duplicate lines (same tag and set pushed twice): both are queued and both are issued in order.
- Snoop:
  - Compares snoop_addr[ADDR_W-1:OFFSET_W] with {tag,set} of every entry that is valid before the edge.
  - snoop_hit is registered 1 cycle after snoop_valid and is 0 in any cycle following snoop_valid=0.
  - An entry being popped in the same cycle still counts as a hit.
  - An entry being pushed in the same cycle does not count as a hit.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset then idle: after rst_n rises, wb_valid=0, evict_ready=1, both counters 0, snoop_hit=0 for any snoop.
- Single M victim (tag=0x0AB, set=0x1234, way=5, mesi=11), wb_ready=1: wb_valid high exactly the next cycle, wb_addr=0x0AB48D00, wb_way=5, pop that cycle, wb_count=1.
- Four M victims back-to-back with wb_ready=0: evict_ready drops after the 4th. A 5th victim stalls. Raising wb_ready drains entries in push order, with evict_ready=1 one cycle after the first pop. The 5th victim is then accepted.
- Victims with mesi=00, 01 and 10: each is accepted, wb_valid stays 0, drop_count=3.
- Snoop of 0x0AB48D3F while that line is pending gives snoop_hit=1 next cycle. Snoop of 0x0AB48D40 gives 0. Snoop in the cycle the line pushes gives 0; snoop in the cycle it pops gives 1.
- Assert rst_n=0 with 3 entries pending and wb_valid=1: outputs return to reset values immediately (asynchronously); after release, no writeback is issued.
